// File: rtl/shift_left2.sv
// Registered shift-left-by-2 (x4) unit: result, the two discarded MSBs and a
// signed-overflow flag are all captured on a valid strobe, one cycle latency.
module shift_left2 #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] A,
  output logic [N-1:0] Y,
  output logic         out_valid,
  output logic [1:0]   lost,
  output logic         ovf
);

  logic [N-1:0] w_y;
  logic [1:0]   w_lost;
  logic         w_ovf;

  logic [N-1:0] r_y;
  logic [1:0]   r_lost;
  logic         r_ovf;
  logic         r_valid;

  // A*4 keeps its sign only when the top three bits of A agree.
  always_comb begin
    w_y    = {A[N-3:0], 2'b00};
    w_lost = A[N-1:N-2];
    w_ovf  = ~((A[N-1] == A[N-2]) & (A[N-2] == A[N-3]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y     <= '0;
      r_lost  <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_y    <= w_y;
        r_lost <= w_lost;
        r_ovf  <= w_ovf;
      end
    end
  end

  assign Y         = r_y;
  assign lost      = r_lost;
  assign ovf       = r_ovf;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_shift_left2.sv
// Bench for shift_left2 at N=32 and N=8, with an arithmetic reference model
// plus directed vectors for reset, overflow boundaries and back-to-back use.
module tb_shift_left2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv32, iv8;
  logic [31:0] a32;
  logic [7:0]  a8;
  logic [31:0] y32;
  logic [7:0]  y8;
  logic        ov32, ov8;
  logic [1:0]  lost32, lost8;
  logic        ovf32, ovf8;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] e_y32;
  logic [1:0]  e_lost32;
  logic        e_ovf32, e_v32;
  logic [7:0]  e_y8;
  logic [1:0]  e_lost8;
  logic        e_ovf8, e_v8;

  always #5 clk = ~clk;

  shift_left2 #(.N(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .A(a32),
    .Y(y32), .out_valid(ov32), .lost(lost32), .ovf(ovf32)
  );

  shift_left2 #(.N(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .A(a8),
    .Y(y8), .out_valid(ov8), .lost(lost8), .ovf(ovf8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: unsigned product modulo 2^n; overflow when 4*A (as signed) leaves the n-bit signed range.
  function automatic longint unsigned ref_y(longint unsigned a, int n);
    return (a * 4) % (64'd1 << n);
  endfunction

  function automatic longint unsigned ref_lost(longint unsigned a, int n);
    return a / (64'd1 << (n - 2));
  endfunction

  function automatic logic ref_ovf(longint unsigned a, int n);
    longint s, p, lim;
    lim = longint'(64'd1 << (n - 1));
    s   = (a >= (64'd1 << (n - 1))) ? longint'(a) - 2 * lim : longint'(a);
    p   = s * 4;
    return (p >= lim) || (p < -lim);
  endfunction

  task automatic model_reset();
    e_y32 = '0; e_lost32 = '0; e_ovf32 = 1'b0; e_v32 = 1'b0;
    e_y8  = '0; e_lost8  = '0; e_ovf8  = 1'b0; e_v8  = 1'b0;
  endtask

  task automatic check_all(input string ph);
    check({ph, "_y32"},    y32,           e_y32);
    check({ph, "_lost32"}, {30'd0, lost32}, {30'd0, e_lost32});
    check({ph, "_ovf32"},  {31'd0, ovf32},  {31'd0, e_ovf32});
    check({ph, "_v32"},    {31'd0, ov32},   {31'd0, e_v32});
    check({ph, "_y8"},     {24'd0, y8},     {24'd0, e_y8});
    check({ph, "_lost8"},  {30'd0, lost8},  {30'd0, e_lost8});
    check({ph, "_ovf8"},   {31'd0, ovf8},   {31'd0, e_ovf8});
    check({ph, "_v8"},     {31'd0, ov8},    {31'd0, e_v8});
  endtask

  task automatic step(input string ph, input logic v, input logic [31:0] a,
                      input logic v8, input logic [7:0] b);
    @(negedge clk);
    iv32 = v;  a32 = a;
    iv8  = v8; a8  = b;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      e_v32 = v;
      if (v) begin
        e_y32    = 32'(ref_y(longint'(a), 32));
        e_lost32 = 2'(ref_lost(longint'(a), 32));
        e_ovf32  = ref_ovf(longint'(a), 32);
      end
      e_v8 = v8;
      if (v8) begin
        e_y8    = 8'(ref_y(longint'(b), 8));
        e_lost8 = 2'(ref_lost(longint'(b), 8));
        e_ovf8  = ref_ovf(longint'(b), 8);
      end
    end
    check_all(ph);
  endtask

  logic [31:0] vec_a    [4] = '{32'hC000_0001, 32'hE000_0000, 32'h2000_0000, 32'h1FFF_FFFF};
  logic [31:0] vec_y    [4] = '{32'h0000_0004, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFC};
  logic [1:0]  vec_lost [4] = '{2'b11, 2'b11, 2'b00, 2'b00};
  logic        vec_ovf  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    rst_n = 1'b0;
    iv32 = 1'b1; a32 = 32'hFFFF_FFFF;
    iv8  = 1'b1; a8  = 8'hFF;
    model_reset();
    #1;
    check_all("rst_t0");
    for (int i = 0; i < 3; i++) step("rst_hold", 1'b1, 32'hFFFF_FFFF, 1'b1, 8'hFF);

    @(negedge clk);
    rst_n = 1'b1;

    step("basic", 1'b1, 32'h0000_000F, 1'b1, 8'h0F);
    check("basic_y_const", y32, 32'h0000_003C);
    check("basic_y8_const", {24'd0, y8}, 32'h0000_003C);
    step("hold", 1'b0, 32'hx, 1'b0, 8'hx);
    check("hold_y_const", y32, 32'h0000_003C);
    check("hold_v_const", {31'd0, ov32}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      step("vec", 1'b1, vec_a[i], 1'b1, 8'($urandom));
      check("vec_y", y32, vec_y[i]);
      check("vec_lost", {30'd0, lost32}, {30'd0, vec_lost[i]});
      check("vec_ovf", {31'd0, ovf32}, {31'd0, vec_ovf[i]});
    end

    for (int i = 1; i <= 3; i++) begin
      step("b2b", 1'b1, 32'(i), 1'b1, 8'(i));
      check("b2b_y", y32, 32'(4 * i));
      check("b2b_v", {31'd0, ov32}, 32'd1);
    end

    // Reset dropped mid-high-phase must clear outputs before the next edge.
    step("pre_arst", 1'b1, 32'h0000_000F, 1'b1, 8'h0F);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    step("arst_edge", 1'b1, 32'h1234_5678, 1'b1, 8'h55);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_arst", 1'b1, 32'h0000_0005, 1'b1, 8'h05);
    check("post_arst_y", y32, 32'h0000_0014);

    for (int i = 0; i < 1000; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), $urandom,
           ($urandom_range(0, 3) != 0), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_left2.md
Name: shift_left2

Overview:
- Registered shift-left-by-2 (multiply by 4) unit for the datapath, e.g. branch-offset and word-address scaling ahead of the PC adder.
- Takes an N-bit operand A and produces Y = A << 2 one clock after a valid strobe.
- Also reports the two discarded MSBs and a signed-overflow flag, so downstream logic can detect lost magnitude.

Parameters:
- N, 32, operand/result width in bits; legal range N >= 3.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  qualifies A this cycle.
- A  input  N  operand.
- Y  output  N  registered result, {A[N-3:0], 2'b00}.
- out_valid  output  1  Y/lost/ovf hold a result captured on the previous enabled edge.
- lost  output  2  registered A[N-1:N-2], the bits shifted out.
- ovf  output  1  registered signed overflow: 1 when A[N-1:N-3] is not all-equal (sign of A*4 differs from sign of A, or magnitude lost).

Behaviour:
- Reset: rst_n low asynchronously forces Y=0, lost=0, ovf=0, out_valid=0 immediately, independent of clk. Outputs stay there while rst_n is low.
- Deassertion of rst_n takes effect at the next rising edge; no capture occurs on an edge where rst_n is low.
- Capture: on a rising edge with rst_n high and in_valid=1:
  - Y <= {A[N-3:0],2'b00}
  - lost <= A[N-1:N-2]
  - ovf <= ~((A[N-1]==A[N-2]) & (A[N-2]==A[N-3]))
  - out_valid <= 1
- Hold: on a rising edge with in_valid=0, Y, lost and ovf hold their values; out_valid <= 0.
- Latency: exactly 1 cycle from the in_valid edge to out_valid/Y. Throughput is one operand per cycle; back-to-back in_valid gives a new result every cycle.
- Arithmetic:
  - Logical shift with zero fill; no rounding or saturation.
  - Y[1:0] is always 0 after any capture.
  - Unsigned wrap: Y == (A*4) mod 2^N.
- No combinational path from A to Y; all outputs are flops.
- X/Z on A while in_valid=0 does not affect outputs.
- Reset mid-stream: asserting rst_n while out_valid=1 clears everything asynchronously. The first valid after release produces a fresh result; no stale data.

Test Plan:
- Reset: hold rst_n=0 with A=0xFFFFFFFF, in_valid=1 over 3 edges -> Y=0, lost=0, ovf=0, out_valid=0 throughout.
- Basic: release reset, A=0x0000000F, in_valid=1 for one edge -> next cycle Y=0x0000003C, lost=2'b00, ovf=0, out_valid=1. Following cycle with in_valid=0 -> Y holds 0x3C, out_valid=0.
- MSB loss: A=0xC0000001 -> Y=0x00000004, lost=2'b11, ovf=1. A=0xE0000000 -> Y=0x80000000, lost=2'b11, ovf=0.
- Positive overflow: A=0x20000000 -> Y=0x80000000, lost=2'b00, ovf=1. A=0x1FFFFFFF -> Y=0x7FFFFFFC, ovf=0.
- Back-to-back: A=1,2,3 on consecutive valid edges -> Y=4,8,12 on consecutive cycles with out_valid high for 3 cycles.
- Async reset mid-operation: drop rst_n between clock edges while Y=0x3C -> Y=0, out_valid=0 before the next edge. Also randomized: 1000 random A against (A<<2) mod 2^32 at N=32, plus one run at N=8.
